hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Generates the Flush/freeze controls consumed by the IF/ID and ID/EX pipeline registers.
//  Sits beside the ID stage. Observes:
//   - ID source registers; EXE and MEM destination/writeback/memory enables.
//   - Taken-branch (B) from EXE.
//   - Ready handshake of the data-memory controller.
//  Stalls the front end on RAW hazards, flushes on taken branches and freezes the whole pipe
//  during multi-cycle memory accesses. Keeps saturating stall/flush performance counters.
// PARAMETERS
//  FWD_EN    1   1: forwarding present, only load-use hazards stall; 0: any RAW hazard stalls
//  WAIT_MAX  15  max MEM_WAIT cycles before mem_timeout asserts (4-bit wait counter)
//  CNT_W     16  width of stall_cnt / flush_cnt
// PORTS
//  clk          in   1      pipeline clock, rising edge
//  rst          in   1      asynchronous reset, active-low
//  src1         in   4      ID Rn index
//  src2         in   4      ID Rm/Rd index
//  two_src      in   1      ID instruction reads src2
//  id_valid     in   1      ID holds a real (non-bubble) instruction
//  EXE_Dest     in   4      destination in EXE
//  EXE_WB_EN    in   1      EXE will write back
//  EXE_MEM_R_EN in   1      EXE instruction is a load
//  MEM_Dest     in   4      destination in MEM
//  MEM_WB_EN    in   1      MEM will write back
//  B_exe        in   1      branch taken, resolved in EXE
//  mem_req      in   1      MEM stage issues read/write (MEM_R_EN|MEM_W_EN)
//  mem_ready    in   1      memory controller completes access this cycle
//  freeze_IF    out  1      hold PC and IF/ID register
//  freeze_ID    out  1      hold ID/EX inputs; insert bubble into ID/EX
//  freeze_all   out  1      hold every pipeline register (EXE/MEM/WB included)
//  Flush        out  1      clear IF/ID and ID/EX registers on next edge
//  mem_timeout  out  1      sticky: a wait exceeded WAIT_MAX; cleared only by reset
//  stall_cnt    out  CNT_W  cycles with any freeze asserted, saturating
//  flush_cnt    out  CNT_W  cycles with Flush asserted, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): state=RUN; wait_cnt=0; mem_timeout=0; stall_cnt=0; flush_cnt=0.
//    All control outputs 0 while in reset.
//  - hz_exe = EXE_WB_EN & (src1==EXE_Dest | two_src&src2==EXE_Dest);
//    hz_mem is the same test against MEM_Dest/MEM_WB_EN.
//  - raw = id_valid & (FWD_EN ? hz_exe&EXE_MEM_R_EN : hz_exe|hz_mem).
//  - FSM, 2 states:
//    - RUN -> MEM_WAIT when mem_req & ~mem_ready.
//    - MEM_WAIT -> RUN on the cycle mem_ready=1; that cycle still freezes, release on next edge.
//  - Outputs are combinational from state and inputs. Priority is highest first:
//    1. wait: (RUN & mem_req & ~mem_ready) or (MEM_WAIT & ~mem_ready) or (MEM_WAIT & mem_ready)
//       -> freeze_all=freeze_IF=freeze_ID=1, Flush=0.
//       A simultaneous B_exe is held (EXE frozen) and flushes on the first non-wait cycle.
//    2. B_exe -> Flush=1, no freeze. A concurrent raw is dropped (that instruction is killed).
//    3. raw -> freeze_IF=freeze_ID=1 (bubble), freeze_all=0. Load-use stalls exactly 1 cycle.
//    4. otherwise all 0.
//  - mem_req & mem_ready in RUN: zero-wait access, no freeze, stays RUN.
//  - wait_cnt: increments each MEM_WAIT cycle and clears on exit.
//    mem_timeout sets when wait_cnt reaches WAIT_MAX. Freeze is held regardless; no abort.
//  - Counters: +1 per qualifying cycle and saturate at all-ones (no wrap).
//    A cycle counts once in stall_cnt even if several freezes are set.
//  - rst asserted mid-wait: immediate return to RUN, all outputs 0; no pending flush retained.
// TESTING
//  1. Load r3 in EXE (EXE_MEM_R_EN=1, EXE_Dest=3), ID src1=3, FWD_EN=1
//     -> freeze_IF=freeze_ID=1 for 1 cycle, then 0.
//     Same with the ALU op (EXE_MEM_R_EN=0) -> no stall.
//  2. FWD_EN=0, MEM_WB_EN=1, MEM_Dest=5, two_src=1, src2=5 -> stall.
//     Same with two_src=0 -> no stall.
//  3. B_exe=1 together with a load-use raw -> Flush=1, freezes 0, flush_cnt +1.
//  4. mem_req=1, mem_ready low 4 cycles then high -> freeze_all=1 for 5 cycles, stall_cnt +5.
//     B_exe held high throughout -> Flush=1 in the cycle after release.
//  5. mem_ready held low 16 cycles (WAIT_MAX=15) -> mem_timeout=1 and stays 1 after release.
//     Assert rst mid-wait -> all outputs 0 asynchronously.
//  6. Force stall_cnt to all-ones via a long wait (CNT_W=4) -> holds at 4'hF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW-stall, branch-flush and memory-wait freeze control for the ID stage,
// with a sticky wait timeout and saturating stall/flush cycle counters.
module hazard_ctrl #(
    parameter bit         FWD_EN   = 1'b1,
    parameter logic [3:0] WAIT_MAX = 4'd15,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_valid,
    input  logic [3:0]       EXE_Dest,
    input  logic             EXE_WB_EN,
    input  logic             EXE_MEM_R_EN,
    input  logic [3:0]       MEM_Dest,
    input  logic             MEM_WB_EN,
    input  logic             B_exe,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_IF,
    output logic             freeze_ID,
    output logic             freeze_all,
    output logic             Flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    state_t           state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             hz_exe, hz_mem, raw, mem_wait, waiting;

    always_comb begin
        hz_exe     = EXE_WB_EN & ((src1 == EXE_Dest) | (two_src & (src2 == EXE_Dest)));
        hz_mem     = MEM_WB_EN & ((src1 == MEM_Dest) | (two_src & (src2 == MEM_Dest)));
        raw        = id_valid & (FWD_EN ? (hz_exe & EXE_MEM_R_EN) : (hz_exe | hz_mem));
        waiting    = state_q == MEM_WAIT;
        // Outputs are gated by rst so they read 0 while reset is held, whatever the inputs.
        mem_wait   = rst & (waiting | (mem_req & ~mem_ready));
        freeze_all = mem_wait;
        Flush      = rst & ~mem_wait & B_exe;
        freeze_IF  = mem_wait | (rst & ~B_exe & raw);
        freeze_ID  = freeze_IF;
        state_d    = waiting ? (mem_ready ? RUN : MEM_WAIT)
                             : ((mem_req & ~mem_ready) ? MEM_WAIT : RUN);
        wait_cnt_d = (waiting & ~mem_ready) ? ((wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1) : 4'd0;
        timeout_d  = timeout_q | (waiting & ~mem_ready & (wait_cnt_d == WAIT_MAX));
        stall_d    = stall_q + CNT_W'(freeze_IF & ~(&stall_q));
        flush_d    = flush_q + CNT_W'(Flush & ~(&flush_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
endmodule
